// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the Core101 front end.
// Owns the architectural PC and picks the next PC by priority:
// correction from execute, then prediction, then PC+4. Keeps at most one
// memory request in flight and discards responses made stale by a correction.
//
// Ports:
//   clock_in, reset_in                 clock, synchronous active-high reset
//   fetch_correction_en/addr_in        execute-stage redirect
//   fetch_prediction_en/addr_in        predictor target for the held instruction
//   imem_req_valid/ready, _addr_out    instruction-memory request handshake
//   imem_resp_valid_in, _data_in       instruction-memory response
//   fetch_valid/ready, instr/pc/pred   instruction handoff to decode
module fetch_ctrl #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic            fetch_correction_en_in,
  input  logic [XLEN-1:0] fetch_correction_addr_in,
  input  logic            fetch_prediction_en_in,
  input  logic [XLEN-1:0] fetch_prediction_addr_in,
  output logic            imem_req_valid_out,
  input  logic            imem_req_ready_in,
  output logic [XLEN-1:0] imem_req_addr_out,
  input  logic            imem_resp_valid_in,
  input  logic [31:0]     imem_resp_data_in,
  output logic            fetch_valid_out,
  input  logic            fetch_ready_in,
  output logic [31:0]     fetch_instr_out,
  output logic [XLEN-1:0] fetch_pc_out,
  output logic            fetch_pred_out
);

  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            pred_q, pred_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            out_pred_q, out_pred_d;

  // State and datapath registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      kill_q     <= 1'b0;
      pred_q     <= 1'b0;
      instr_q    <= '0;
      out_pc_q   <= '0;
      out_pred_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      pred_q     <= pred_d;
      instr_q    <= instr_d;
      out_pc_q   <= out_pc_d;
      out_pred_q <= out_pred_d;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    pred_d     = pred_q;
    instr_d    = instr_q;
    out_pc_d   = out_pc_q;
    out_pred_d = out_pred_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready_in) begin
          state_d = WAIT;
          // A correction in the accept cycle makes this request stale
          kill_d  = fetch_correction_en_in;
        end
      end
      WAIT: begin
        if (imem_resp_valid_in) begin
          kill_d = 1'b0;
          if (kill_q || fetch_correction_en_in) begin
            state_d = REQ;
          end else begin
            instr_d    = imem_resp_data_in;
            out_pc_d   = pc_q;
            out_pred_d = pred_q;
            state_d    = HOLD;
          end
        end else if (fetch_correction_en_in) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (fetch_correction_en_in) begin
          state_d = REQ;
        end else if (fetch_ready_in) begin
          pc_d    = fetch_prediction_en_in ? fetch_prediction_addr_in
                                           : pc_q + XLEN'(4);
          pred_d  = fetch_prediction_en_in;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Correction overrides every other PC source outside IDLE
    if (fetch_correction_en_in && (state_q != IDLE)) begin
      pc_d   = fetch_correction_addr_in;
      pred_d = 1'b0;
    end
  end

  // Handshake valids decode from the state register only
  assign imem_req_valid_out = (state_q == REQ);
  assign imem_req_addr_out  = pc_q;
  assign fetch_valid_out    = (state_q == HOLD);
  assign fetch_instr_out    = instr_q;
  assign fetch_pc_out       = out_pc_q;
  assign fetch_pred_out     = out_pred_q;

endmodule
